// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: bus widths, reset vector and fetch FSM encoding.
package cpu_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned INSTR_W = 16;

  localparam logic [ADDR_W-1:0] RESET_ADDR_DEFAULT = 16'h0000;

  typedef enum logic {
    FS_RUN  = 1'b0,
    FS_HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [INSTR_W-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_queue_if.sv
// Fetch front-end bundle: instruction-memory request/response and decode handshake.
interface ifetch_queue_if;

  logic                         redirect;
  logic [cpu_pkg::ADDR_W-1:0]   redirect_addr;
  logic                         hlt;
  logic                         mem_req;
  logic [cpu_pkg::ADDR_W-1:0]   mem_addr;
  logic                         mem_gnt;
  logic                         mem_rvalid;
  logic [cpu_pkg::INSTR_W-1:0]  mem_rdata;
  logic                         instr_valid;
  logic [cpu_pkg::INSTR_W-1:0]  instr;
  logic [cpu_pkg::ADDR_W-1:0]   instr_addr;
  logic                         instr_ready;

  // master is the fetch unit, slave is the memory/decode environment
  modport master (
    input  redirect, redirect_addr, hlt, mem_gnt, mem_rvalid, mem_rdata, instr_ready,
    output mem_req, mem_addr, instr_valid, instr, instr_addr
  );

  modport slave (
    output redirect, redirect_addr, hlt, mem_gnt, mem_rvalid, mem_rdata, instr_ready,
    input  mem_req, mem_addr, instr_valid, instr, instr_addr
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue of {addr, data}; flush wins over push and pop.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output fetch_entry_t     head
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: issues in-order memory requests, buffers responses
// for decode, flushes on redirect and stops issuing after halt.
module ifetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned       DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = RESET_ADDR_DEFAULT
) (
  input logic            clk,
  input logic            rst,
  ifetch_queue_if.master bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned SUM_W = CNT_W + 1;

  fetch_state_e      state;
  fetch_state_e      state_next;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [CNT_W-1:0]  outst;
  logic [CNT_W-1:0]  drop;
  logic [CNT_W-1:0]  count;
  logic              room;
  logic              req;
  logic              grant;
  logic              accept;
  logic              pop;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;

  // queued plus in-flight never exceeds DEPTH, so pushes cannot overflow
  assign room = (SUM_W'(count) + SUM_W'(outst)) < SUM_W'(DEPTH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FS_RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    req        = 1'b0;
    case (state)
      FS_RUN: begin
        req = !rst && !bus.redirect && !bus.hlt && room;
        if (bus.hlt) state_next = FS_HALT;
      end
      FS_HALT: state_next = FS_HALT;
    endcase
  end

  assign grant      = req && bus.mem_gnt;
  assign accept     = bus.mem_rvalid && (drop == '0) && !bus.redirect;
  assign pop        = bus.instr_valid && bus.instr_ready;
  assign push_entry = '{addr: resp_pc, data: bus.mem_rdata};

  // On redirect every request still in flight becomes stale
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_ADDR;
      resp_pc  <= RESET_ADDR;
      outst    <= '0;
      drop     <= '0;
    end else if (bus.redirect) begin
      fetch_pc <= bus.redirect_addr;
      resp_pc  <= bus.redirect_addr;
      outst    <= outst - CNT_W'(bus.mem_rvalid);
      drop     <= outst - CNT_W'(bus.mem_rvalid);
    end else begin
      if (grant) fetch_pc <= fetch_pc + ADDR_W'(1);
      if (accept) resp_pc <= resp_pc + ADDR_W'(1);
      outst <= outst + CNT_W'(grant) - CNT_W'(bus.mem_rvalid);
      if (bus.mem_rvalid && (drop != '0)) drop <= drop - CNT_W'(1);
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (bus.redirect),
    .push       (accept),
    .push_entry (push_entry),
    .pop        (pop),
    .count      (count),
    .head       (head)
  );

  assign bus.mem_req     = req;
  assign bus.mem_addr    = fetch_pc;
  assign bus.instr_valid = (count != '0);
  assign bus.instr       = head.data;
  assign bus.instr_addr  = head.addr;

endmodule
